// File: rtl/actuated_intersection_scheduler.sv
// actuated_intersection_scheduler: demand-actuated NS/EW/pedestrian phase sequencer with
// min/max green, yellow, all-red clearance and walk timing; lamp outputs are registered.
module actuated_intersection_scheduler #(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 10,
    parameter int YELLOW_T  = 3,
    parameter int ALL_RED_T = 2,
    parameter int WALK_T    = 5,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic [2:0] NS,
    output logic [2:0] EW,
    output logic       walk,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        ALL_R = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        PED   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] MIN_L  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_L  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_L  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_L   = CNT_W'(ALL_RED_T - 1);
    localparam logic [CNT_W-1:0] WALK_L = CNT_W'(WALK_T - 1);
    localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic             dir_q, dir_d;
    logic             ns_pend_q, ns_pend_d;
    logic             ew_pend_q, ew_pend_d;
    logic             ped_pend_q, ped_pend_d;
    logic [2:0]       ns_q, ns_d, ew_q, ew_d;
    logic             walk_q, walk_d;

    // dir_q: 0 = NS is next green, 1 = EW is next green
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        case (state_q)
            NS_G:  if (tmr_q >= MIN_L && (ew_pend_q | ped_pend_q) && (!ns_req || tmr_q >= MAX_L))
                       state_d = NS_Y;
            NS_Y:  if (tmr_q >= YEL_L) begin
                       state_d = ALL_R;
                       dir_d   = 1'b1;
                   end
            ALL_R: if (tmr_q >= AR_L)
                       state_d = ped_pend_q ? PED : (dir_q ? EW_G : NS_G);
            EW_G:  if (tmr_q >= MIN_L && (ns_pend_q | ped_pend_q) && (!ew_req || tmr_q >= MAX_L))
                       state_d = EW_Y;
            EW_Y:  if (tmr_q >= YEL_L) begin
                       state_d = ALL_R;
                       dir_d   = 1'b0;
                   end
            PED:   if (tmr_q >= WALK_L)
                       state_d = dir_q ? EW_G : NS_G;
            default: state_d = ALL_R;
        endcase
        tmr_d      = (state_d != state_q) ? '0 : (tmr_q >= MAX_L ? tmr_q : tmr_q + 1'b1);
        // entering a phase consumes its own request, even one arriving on that same edge
        ns_pend_d  = (state_d == NS_G) ? 1'b0 : (ns_pend_q | (ns_req && state_q != NS_G));
        ew_pend_d  = (state_d == EW_G) ? 1'b0 : (ew_pend_q | (ew_req && state_q != EW_G));
        ped_pend_d = (state_d == PED) ? 1'b0 : (ped_pend_q | (ped_req && state_q != PED));
        ns_d       = state_d == NS_G ? GRN : (state_d == NS_Y ? YEL : RED);
        ew_d       = state_d == EW_G ? GRN : (state_d == EW_Y ? YEL : RED);
        walk_d     = state_d == PED;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ALL_R;
            tmr_q      <= '0;
            dir_q      <= 1'b0;
            ns_pend_q  <= 1'b0;
            ew_pend_q  <= 1'b0;
            ped_pend_q <= 1'b0;
            ns_q       <= RED;
            ew_q       <= RED;
            walk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            dir_q      <= dir_d;
            ns_pend_q  <= ns_pend_d;
            ew_pend_q  <= ew_pend_d;
            ped_pend_q <= ped_pend_d;
            ns_q       <= ns_d;
            ew_q       <= ew_d;
            walk_q     <= walk_d;
        end
    end

    assign NS    = ns_q;
    assign EW    = ew_q;
    assign walk  = walk_q;
    assign phase = state_q;
endmodule

// File: tb/tb_actuated_intersection_scheduler.sv
// tb_actuated_intersection_scheduler: directed scenarios with hand-derived phase sequences,
// plus a per-cycle lamp safety/decoding monitor.
module tb_actuated_intersection_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ns_req = 1'b0, ew_req = 1'b0, ped_req = 1'b0;
    logic [2:0] NS, EW, phase;
    logic       walk;
    int         tests = 0, fails = 0;
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    actuated_intersection_scheduler dut (
        .clk(clk), .reset(reset), .ns_req(ns_req), .ew_req(ew_req), .ped_req(ped_req),
        .NS(NS), .EW(EW), .walk(walk), .phase(phase)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic logic [6:0] lamps(input logic [2:0] p);
        case (p)
            3'd0:    return {3'b001, 3'b100, 1'b0};
            3'd1:    return {3'b010, 3'b100, 1'b0};
            3'd2:    return {3'b100, 3'b100, 1'b0};
            3'd3:    return {3'b100, 3'b001, 1'b0};
            3'd4:    return {3'b100, 3'b010, 1'b0};
            3'd5:    return {3'b100, 3'b100, 1'b1};
            default: return 7'bx;
        endcase
    endfunction

    always @(negedge clk) if (mon_en) begin
        tests++;
        if (!$onehot(NS) || !$onehot(EW) || (NS != 3'b100 && EW != 3'b100) ||
            (walk && (NS != 3'b100 || EW != 3'b100)) || {NS, EW, walk} !== lamps(phase)) begin
            fails++;
            $display("FAIL invariant t=%0t phase=%0d NS=%b EW=%b walk=%b", $time, phase, NS, EW, walk);
        end
    end

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) tick();
        mon_en = 1'b1;
        tests++;
        if ({phase, NS, EW, walk} !== {3'd2, 3'b100, 3'b100, 1'b0}) begin
            fails++;
            $display("FAIL reset_state got phase=%0d NS=%b EW=%b walk=%b want 2 100 100 0", phase, NS, EW, walk);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (phase !== 3'd2) begin
            fails++;
            $display("FAIL release_allred got %0d want 2", phase);
        end
        tick();
        tests++;
        if (phase !== 3'd0 || NS !== 3'b001) begin
            fails++;
            $display("FAIL ns_green_entry got phase=%0d NS=%b want 0 001", phase, NS);
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            tests++;
            if (phase !== 3'd0) begin
                fails++;
                $display("FAIL ns_rest cycle %0d got %0d want 0", i, phase);
            end
        end
    endtask

    task automatic test_ew_pulse;
        logic [2:0] exp [8] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        ew_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            ew_req = 1'b0;
            tests++;
            if (phase !== exp[i]) begin
                fails++;
                $display("FAIL ew_pulse step %0d got %0d want %0d", i, phase, exp[i]);
            end
        end
    endtask

    task automatic test_max_out;
        logic [2:0] want;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ns_req = 1'b1;
        repeat (2) tick();
        tests++;
        if (phase !== 3'd0) begin
            fails++;
            $display("FAIL maxout_entry got %0d want 0", phase);
        end
        ew_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            ew_req = 1'b0;
            want = i < 9 ? 3'd0 : (i < 12 ? 3'd1 : (i < 14 ? 3'd2 : 3'd3));
            tests++;
            if (phase !== want) begin
                fails++;
                $display("FAIL max_out step %0d got %0d want %0d", i, phase, want);
            end
        end
    endtask

    task automatic test_ped;
        logic [2:0] exp [14] = '{3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd2, 3'd2,
                                 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd0};
        ns_req  = 1'b1;
        ped_req = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            ns_req  = 1'b0;
            ped_req = 1'b0;
            tests++;
            if (phase !== exp[i] || walk !== (exp[i] == 3'd5)) begin
                fails++;
                $display("FAIL ped step %0d got phase=%0d walk=%b want %0d %b", i, phase, walk, exp[i], exp[i] == 3'd5);
            end
        end
    endtask

    task automatic test_reset_mid;
        ew_req = 1'b1;
        tick();
        ew_req = 1'b0;
        repeat (4) tick();
        tests++;
        if (phase !== 3'd1) begin
            fails++;
            $display("FAIL mid_in_ns_y got %0d want 1", phase);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if ({phase, NS, EW, walk} !== {3'd2, 3'b100, 3'b100, 1'b0}) begin
            fails++;
            $display("FAIL mid_reset got phase=%0d NS=%b EW=%b walk=%b want 2 100 100 0", phase, NS, EW, walk);
        end
        tick();
        tests++;
        if (phase !== 3'd2) begin
            fails++;
            $display("FAIL mid_release got %0d want 2", phase);
        end
        tick();
        tests++;
        if (phase !== 3'd0) begin
            fails++;
            $display("FAIL mid_restart got %0d want 0", phase);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            tests++;
            if (phase !== 3'd0) begin
                fails++;
                $display("FAIL mid_pend_lost cycle %0d got %0d want 0", i, phase);
            end
        end
    endtask

    task automatic test_consume;
        logic [2:0] a [6] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2};
        logic [2:0] b [9] = '{3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd2, 3'd2, 3'd0};
        ew_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            ew_req = 1'b0;
            tests++;
            if (phase !== a[i]) begin
                fails++;
                $display("FAIL consume_a step %0d got %0d want %0d", i, phase, a[i]);
            end
        end
        ew_req = 1'b1;
        tick();
        ew_req = 1'b0;
        tests++;
        if (phase !== 3'd3) begin
            fails++;
            $display("FAIL consume_ew_entry got %0d want 3", phase);
        end
        ns_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            ns_req = 1'b0;
            tests++;
            if (phase !== b[i]) begin
                fails++;
                $display("FAIL consume_b step %0d got %0d want %0d", i, phase, b[i]);
            end
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            tests++;
            if (phase !== 3'd0) begin
                fails++;
                $display("FAIL consume_rest cycle %0d got %0d want 0", i, phase);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ew_pulse();
        test_max_out();
        test_ped();
        test_reset_mid();
        test_consume();
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
